// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line requests and converts each grant into a
// four-beat burst on the physical-memory port.
// Latency: 1 grant cycle, then one cycle per pmem_resp strobe, then 1 resp cycle.
// Backpressure: requests are held by the caches until their resp pulse; bursts wait on pmem_resp.
module pmem_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [31:0]       icache_address,
  output logic [LINE_W-1:0] icache_rline,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [31:0]       dcache_address,
  input  logic [LINE_W-1:0] dcache_wline,
  output logic [LINE_W-1:0] dcache_rline,
  output logic              dcache_resp,
  input  logic              pmem_resp,
  input  logic [BEAT_W-1:0] pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-within-line offset so pmem always sees a line-aligned address.
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [2:0] {IDLE, IRD, DRD, DWR, RESP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   beat_q;
  logic [CNT_W-1:0]   beat_d;
  logic               last_d_q;     // 1 when the D-cache was the last source served
  logic               src_d_q;      // 1 when the current grant belongs to the D-cache
  logic [LINE_W-1:0]  line_q;       // write-back line or read line under assembly
  logic [LINE_W-1:0]  line_d;
  logic               i_req;
  logic               d_req;
  logic               grant_d;
  logic               icache_resp_q;
  logic               dcache_resp_q;
  logic [LINE_W-1:0]  icache_rline_q;
  logic [LINE_W-1:0]  dcache_rline_q;
  logic               pmem_read_q;
  logic               pmem_write_q;
  logic [31:0]        pmem_address_q;

  // Request decode, round-robin winner and next line/beat values.
  always_comb begin
    i_req   = icache_read;
    d_req   = dcache_read | dcache_write;
    // On a tie the D-cache wins unless it was the one served last.
    grant_d = d_req & (~i_req | ~last_d_q);
    beat_d  = beat_q + CNT_W'(1);
    line_d  = line_q;
    line_d[BEAT_W*beat_q +: BEAT_W] = pmem_rdata;
  end

  // Main FSM: grant in IDLE, count beats in IRD/DRD/DWR, pulse resp in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      last_d_q       <= 1'b0;
      src_d_q        <= 1'b0;
      line_q         <= '0;
      icache_resp_q  <= 1'b0;
      dcache_resp_q  <= 1'b0;
      icache_rline_q <= '0;
      dcache_rline_q <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            src_d_q <= grant_d;
            beat_q  <= '0;
            if (grant_d) begin
              pmem_address_q <= dcache_address & LINE_MASK;
              // A simultaneous read+write from the D-cache is served as the write.
              if (dcache_write) begin
                line_q       <= dcache_wline;
                pmem_write_q <= 1'b1;
                state_q      <= DWR;
              end else begin
                pmem_read_q <= 1'b1;
                state_q     <= DRD;
              end
            end else begin
              pmem_address_q <= icache_address & LINE_MASK;
              pmem_read_q    <= 1'b1;
              state_q        <= IRD;
            end
          end
        end
        IRD, DRD: begin
          if (pmem_resp) begin
            line_q <= line_d;
            beat_q <= beat_d;
            if (beat_q == LAST_BEAT) begin
              beat_q         <= '0;
              pmem_read_q    <= 1'b0;
              pmem_address_q <= '0;
              state_q        <= RESP;
              if (src_d_q) begin
                dcache_resp_q  <= 1'b1;
                dcache_rline_q <= line_d;
              end else begin
                icache_resp_q  <= 1'b1;
                icache_rline_q <= line_d;
              end
            end
          end
        end
        DWR: begin
          if (pmem_resp) begin
            beat_q <= beat_d;
            if (beat_q == LAST_BEAT) begin
              beat_q         <= '0;
              pmem_write_q   <= 1'b0;
              pmem_address_q <= '0;
              dcache_resp_q  <= 1'b1;
              state_q        <= RESP;
            end
          end
        end
        RESP: begin
          icache_resp_q  <= 1'b0;
          dcache_resp_q  <= 1'b0;
          icache_rline_q <= '0;
          dcache_rline_q <= '0;
          last_d_q       <= src_d_q;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign icache_resp  = icache_resp_q;
  assign dcache_resp  = dcache_resp_q;
  assign icache_rline = icache_rline_q;
  assign dcache_rline = dcache_rline_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  // Write data follows the beat counter directly so each strobe sees the next beat.
  assign pmem_wdata   = pmem_write_q ? line_q[BEAT_W*beat_q +: BEAT_W] : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: transaction-level model plus directed scenarios.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         icache_read = 1'b0;
  logic [31:0]  icache_address = '0;
  logic [255:0] icache_rline;
  logic         icache_resp;
  logic         dcache_read = 1'b0;
  logic         dcache_write = 1'b0;
  logic [31:0]  dcache_address = '0;
  logic [255:0] dcache_wline = '0;
  logic [255:0] dcache_rline;
  logic         dcache_resp;
  logic         pmem_resp = 1'b0;
  logic [63:0]  pmem_rdata = '0;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rline(icache_rline), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wline(dcache_wline),
    .dcache_rline(dcache_rline), .dcache_resp(dcache_resp),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit           m_busy = 0, m_in_resp = 0, m_src_d = 0, m_wr = 0, m_last_d = 0;
  int           m_beats = 0;
  logic [63:0]  m_words [4];
  logic [31:0]  m_addr;
  logic         exp_iresp = 0, exp_dresp = 0, exp_pread = 0, exp_pwrite = 0;
  logic [31:0]  exp_addr = '0;
  logic [255:0] exp_line = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy = 0; m_in_resp = 0; m_last_d = 0; m_beats = 0;
      exp_iresp = 0; exp_dresp = 0; exp_pread = 0; exp_pwrite = 0; exp_addr = '0;
    end else if (m_in_resp) begin
      m_last_d  = m_src_d;
      m_in_resp = 0;
      exp_iresp = 0; exp_dresp = 0;
    end else if (!m_busy) begin
      if (icache_read || dcache_read || dcache_write) begin
        if (icache_read && (dcache_read || dcache_write)) m_src_d = !m_last_d;
        else m_src_d = !icache_read;
        m_wr     = m_src_d && dcache_write;
        m_addr   = m_src_d ? dcache_address : icache_address;
        exp_addr = {m_addr[31:5], 5'b0};
        for (int k = 0; k < 4; k++) m_words[k] = m_wr ? dcache_wline[64*k +: 64] : 64'h0;
        m_busy = 1; m_beats = 0;
        exp_pread = !m_wr; exp_pwrite = m_wr;
      end
    end else if (pmem_resp) begin
      if (!m_wr) m_words[m_beats] = pmem_rdata;
      m_beats++;
      if (m_beats == 4) begin
        m_busy = 0; m_in_resp = 1; m_beats = 0;
        exp_pread = 0; exp_pwrite = 0; exp_addr = '0;
        exp_line = {m_words[3], m_words[2], m_words[1], m_words[0]};
        if (m_src_d) exp_dresp = 1; else exp_iresp = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int i_pulses = 0, d_pulses = 0;
  initial forever begin
    logic [63:0] ew;
    @(negedge clk);
    ew = exp_pwrite ? m_words[m_beats] : 64'h0;
    chk("icache_resp", 256'(icache_resp), 256'(exp_iresp));
    chk("dcache_resp", 256'(dcache_resp), 256'(exp_dresp));
    chk("pmem_read", 256'(pmem_read), 256'(exp_pread));
    chk("pmem_write", 256'(pmem_write), 256'(exp_pwrite));
    chk("pmem_address", 256'(pmem_address), 256'(exp_addr));
    chk("pmem_wdata", 256'(pmem_wdata), 256'(ew));
    if (exp_iresp) begin
      chk("icache_rline", icache_rline, exp_line);
      chk("dcache_rline_idle_side", dcache_rline, 256'h0);
    end
    if (exp_dresp) begin
      if (!m_wr) chk("dcache_rline", dcache_rline, exp_line);
      chk("icache_rline_idle_side", icache_rline, 256'h0);
    end
    if (icache_resp === 1'b1) i_pulses++;
    if (dcache_resp === 1'b1) d_pulses++;
  end

  // ---------------- physical memory ----------------
  logic [15:0] gap_pat = 16'hFFFF;   // bit k: strobe in the k-th cycle of a burst
  bit          idle_noise = 0;       // strobe while no burst is active
  logic [63:0] mem_beat [4];
  logic [63:0] wlog [4];
  int          gp = 0, mb = 0, wbeats = 0;

  initial forever begin
    @(negedge clk);
    if (m_busy) begin
      pmem_resp = gap_pat[gp];
      if (gp < 15) gp++;
      if (pmem_resp) begin
        pmem_rdata = mem_beat[mb];
        if (pmem_write === 1'b1) begin
          wlog[mb] = pmem_wdata;
          wbeats++;
        end
        mb = (mb + 1) % 4;
      end else begin
        pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end else begin
      pmem_resp  = idle_noise;
      pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      gp = 0; mb = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  int           rise_cyc [8];
  logic [31:0]  rise_addr [8];
  int           nrise = 0;
  bit           prev_rd = 0, rd_seen = 0;
  int           i_resp_cyc = 0, d_resp_cyc = 0;
  logic [255:0] i_line, d_line;

  task automatic clear_trk();
    nrise = 0; prev_rd = 0; rd_seen = 0; wbeats = 0;
    for (int k = 0; k < 8; k++) begin rise_cyc[k] = 0; rise_addr[k] = '0; end
  endtask

  task automatic set_beats(input logic [63:0] b0, b1, b2, b3);
    mem_beat[0] = b0; mem_beat[1] = b1; mem_beat[2] = b2; mem_beat[3] = b3;
  endtask

  // Runs until every raised request has been answered and the arbiter is idle.
  task automatic run(input string name, input int budget);
    int n;
    n = 0;
    while ((icache_read || dcache_read || dcache_write || m_busy || m_in_resp) && n < budget) begin
      @(negedge clk);
      n++;
      if (pmem_read === 1'b1) rd_seen = 1;
      if ((pmem_read === 1'b1 || pmem_write === 1'b1) && !prev_rd && nrise < 8) begin
        rise_cyc[nrise]  = cyc;
        rise_addr[nrise] = pmem_address;
        nrise++;
      end
      prev_rd = (pmem_read === 1'b1 || pmem_write === 1'b1);
      if (exp_iresp) begin icache_read = 0; i_resp_cyc = cyc; i_line = icache_rline; end
      if (exp_dresp) begin dcache_read = 0; dcache_write = 0; d_resp_cyc = cyc; d_line = dcache_rline; end
    end
    chk({name, "_completes"}, 256'(n < budget), 256'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, p0, n;
    logic [255:0] wl;

    repeat (3) @(negedge clk);
    chk("rst_icache_resp", 256'(icache_resp), 256'(0));
    chk("rst_dcache_resp", 256'(dcache_resp), 256'(0));
    chk("rst_pmem_read", 256'(pmem_read), 256'(0));
    chk("rst_pmem_write", 256'(pmem_write), 256'(0));
    chk("rst_pmem_address", 256'(pmem_address), 256'(0));
    chk("rst_pmem_wdata", 256'(pmem_wdata), 256'(0));
    chk("rst_icache_rline", icache_rline, 256'h0);
    chk("rst_dcache_rline", dcache_rline, 256'h0);
    rst = 0;
    @(negedge clk);

    // I-read alone, back-to-back beats.
    clear_trk();
    set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    icache_address = 32'h0000_1234;
    icache_read = 1;
    t0 = cyc; p0 = i_pulses;
    run("t1", 50);
    chk("t1_pmem_address", 256'(rise_addr[0]), 256'(32'h0000_1220));
    chk("t1_rline", i_line, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    // Request cycle is cycle 1, resp lands in cycle 6.
    chk("t1_latency", 256'(i_resp_cyc - t0), 256'(5));
    chk("t1_pulses", 256'(i_pulses - p0), 256'(1));

    // D-write of words 0..7.
    clear_trk();
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = 32'(k);
    dcache_wline = wl;
    dcache_address = 32'h8000_0040;
    dcache_write = 1;
    p0 = d_pulses;
    run("t2", 50);
    chk("t2_pmem_address", 256'(rise_addr[0]), 256'(32'h8000_0040));
    chk("t2_write_beats", 256'(wbeats), 256'(4));
    chk("t2_wdata0", 256'(wlog[0]), 256'(64'h0000_0001_0000_0000));
    chk("t2_wdata1", 256'(wlog[1]), 256'(64'h0000_0003_0000_0002));
    chk("t2_wdata2", 256'(wlog[2]), 256'(64'h0000_0005_0000_0004));
    chk("t2_wdata3", 256'(wlog[3]), 256'(64'h0000_0007_0000_0006));
    chk("t2_no_read", 256'(rd_seen), 256'(0));
    chk("t2_pulses", 256'(d_pulses - p0), 256'(1));

    // Simultaneous I and D read straight out of reset: D first.
    rst = 1;
    repeat (2) @(negedge clk);
    clear_trk();
    set_beats(64'hA0, 64'hA1, 64'hA2, 64'hA3);
    icache_address = 32'h0000_0100;
    dcache_address = 32'h0000_0200;
    rst = 0;
    icache_read = 1;
    dcache_read = 1;
    run("t3", 100);
    chk("t3_first_is_d", 256'(rise_addr[0]), 256'(32'h0000_0200));
    chk("t3_second_is_i", 256'(rise_addr[1]), 256'(32'h0000_0100));
    chk("t3_i_grant_gap", 256'(rise_cyc[1] - d_resp_cyc), 256'(2));
    chk("t3_i_resp_gap", 256'(i_resp_cyc - d_resp_cyc), 256'(6));
    // A D-only read makes D the last served, so the next tie goes to I.
    clear_trk();
    dcache_address = 32'h0000_0300;
    dcache_read = 1;
    run("t3b", 50);
    clear_trk();
    icache_address = 32'h0000_0100;
    dcache_address = 32'h0000_0200;
    icache_read = 1;
    dcache_read = 1;
    run("t3c", 100);
    chk("t3c_first_is_i", 256'(rise_addr[0]), 256'(32'h0000_0100));
    chk("t3c_second_is_d", 256'(rise_addr[1]), 256'(32'h0000_0200));

    // D-read with strobe gaps 1,0,0,1,1,0,1 and stray strobes while idle.
    clear_trk();
    gap_pat = 16'hFFD9;
    idle_noise = 1;
    set_beats(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0);
    dcache_address = 32'h4000_009F;
    dcache_read = 1;
    run("t4", 50);
    chk("t4_pmem_address", 256'(rise_addr[0]), 256'(32'h4000_0080));
    chk("t4_rline", d_line, {64'h0F0F_F0F0_0F0F_F0F0, 64'h5555_AAAA_5555_AAAA,
                             64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
    chk("t4_resp_after_4th", 256'(d_resp_cyc - rise_cyc[0]), 256'(7));
    gap_pat = 16'hFFFF;
    idle_noise = 0;
    @(negedge clk);

    // Reset after two beats of a D-read.
    clear_trk();
    set_beats(64'h77, 64'h88, 64'h99, 64'hAA);
    dcache_address = 32'h3000_0000;
    dcache_read = 1;
    p0 = d_pulses;
    n = 0;
    while (!(m_busy && m_beats == 2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_two_beats", 256'(n < 20), 256'(1));
    rst = 1;
    @(negedge clk);
    chk("t5_read_dropped", 256'(pmem_read), 256'(0));
    chk("t5_no_resp_now", 256'(dcache_resp), 256'(0));
    dcache_read = 0;
    rst = 0;
    repeat (4) @(negedge clk);
    chk("t5_no_resp_after", 256'(d_pulses - p0), 256'(0));
    clear_trk();
    set_beats(64'hC0, 64'hC1, 64'hC2, 64'hC3);
    dcache_address = 32'h3000_0020;
    dcache_read = 1;
    run("t5b", 50);
    chk("t5b_rline", d_line, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
    chk("t5b_pulses", 256'(d_pulses - p0), 256'(1));

    // dcache_read and dcache_write together: served as a write.
    clear_trk();
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = 32'(8'hA0 + k);
    dcache_wline = wl;
    dcache_address = 32'h0000_5000;
    dcache_read = 1;
    dcache_write = 1;
    p0 = d_pulses;
    run("t6", 50);
    chk("t6_write_beats", 256'(wbeats), 256'(4));
    chk("t6_no_read", 256'(rd_seen), 256'(0));
    chk("t6_pulses", 256'(d_pulses - p0), 256'(1));
    chk("t6_wdata0", 256'(wlog[0]), 256'(64'h0000_00A1_0000_00A0));
    chk("t6_wdata3", 256'(wlog[3]), 256'(64'h0000_00A7_0000_00A6));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
